// File: rtl/rv_mul_sequencer.sv
// ============================================================================
// Module   : rv_mul_sequencer
// Purpose  : Four-cycle RV32M multiply (MUL/MULH/MULHSU/MULHU) on a shared
//            16x16 multiplier with magnitude-based sign handling.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rv_mul_sequencer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        kill_i,
    input  logic [31:0] d_rs1_i,
    input  logic [31:0] d_rs2_i,
    input  logic [2:0]  d_fun_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ACC  = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [1:0]  count_q;
    logic [63:0] acc_q;
    logic [31:0] mag_a_q, mag_b_q;
    logic        neg_q;
    logic        is_mul_q;
    logic [31:0] result_q;
    logic        done_q;

    logic        w_accept;
    logic        w_acc_en;
    logic        w_fix_en;
    logic        w_sign_a, w_sign_b;
    logic [15:0] w_opa, w_opb;
    logic [5:0]  w_shamt;
    logic [31:0] w_pp;
    logic [63:0] w_pp_sh;
    logic [63:0] w_prod;

    assign w_accept = (state_q == c_IDLE) && start_i && !kill_i && !d_fun_i[2];

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= c_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; kill wins over everything except reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (w_accept) state_d = c_ACC;
            c_ACC:   if (kill_i) state_d = c_IDLE;
                     else if (count_q == 2'd3) state_d = c_FIX;
            c_FIX:   state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        busy_o   = (state_q != c_IDLE);
        w_acc_en = (state_q == c_ACC) && !kill_i;
        w_fix_en = (state_q == c_FIX) && !kill_i;
    end

    // MULHU is unsigned on both sides; MULHSU only on rs2
    assign w_sign_a = d_rs1_i[31] && (d_fun_i[1:0] != 2'b11);
    assign w_sign_b = d_rs2_i[31] && !d_fun_i[1];

    always_comb begin
        w_opa   = mag_a_q[15:0];
        w_opb   = mag_b_q[15:0];
        w_shamt = 6'd0;
        case (count_q)
            2'd0: begin w_opa = mag_a_q[15:0];  w_opb = mag_b_q[15:0];  w_shamt = 6'd0;  end
            2'd1: begin w_opa = mag_a_q[15:0];  w_opb = mag_b_q[31:16]; w_shamt = 6'd16; end
            2'd2: begin w_opa = mag_a_q[31:16]; w_opb = mag_b_q[15:0];  w_shamt = 6'd16; end
            default: begin w_opa = mag_a_q[31:16]; w_opb = mag_b_q[31:16]; w_shamt = 6'd32; end
        endcase
    end

    assign w_pp    = {16'd0, w_opa} * {16'd0, w_opb};
    assign w_pp_sh = {32'd0, w_pp} << w_shamt;
    assign w_prod  = neg_q ? (~acc_q + 64'd1) : acc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q  <= 2'd0;
            acc_q    <= 64'd0;
            mag_a_q  <= 32'd0;
            mag_b_q  <= 32'd0;
            neg_q    <= 1'b0;
            is_mul_q <= 1'b0;
            result_q <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (w_accept) begin
                mag_a_q  <= w_sign_a ? (~d_rs1_i + 32'd1) : d_rs1_i;
                mag_b_q  <= w_sign_b ? (~d_rs2_i + 32'd1) : d_rs2_i;
                neg_q    <= w_sign_a ^ w_sign_b;
                is_mul_q <= (d_fun_i[1:0] == 2'b00);
                acc_q    <= 64'd0;
                count_q  <= 2'd0;
            end
            if (w_acc_en) begin
                acc_q   <= acc_q + w_pp_sh;
                count_q <= count_q + 2'd1;
            end
            if (w_fix_en) begin
                result_q <= is_mul_q ? w_prod[31:0] : w_prod[63:32];
                done_q   <= 1'b1;
            end
        end
    end

    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

`default_nettype wire
